stream_frame_packer: RTL and testbench

STREAM_FRAME_PACKER -- requirements
Module: stream_frame_packer

---
 rtl/stream_frame_pkg.sv | 26 ++
 rtl/frame_out_reg.sv | 33 +++
 rtl/stream_frame_packer.sv | 158 +++++++++++++++
 tb/tb_stream_frame_packer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_frame_pkg.sv
// Shared types and constants for the stream frame packer.
// The optional trailer beat is enabled by defining FRAME_PACKER_TRAILER_EN.
package stream_frame_pkg;

   localparam logic [15:0] FRAME_MAGIC = 16'hE7A5;
   localparam int unsigned SEQ_W       = 12;
   localparam int unsigned CNT_W       = 16;

   localparam logic [3:0] CH_AR = 4'd0;
   localparam logic [3:0] CH_AW = 4'd1;
   localparam logic [3:0] CH_R  = 4'd2;
   localparam logic [3:0] CH_W  = 4'd3;
   localparam logic [3:0] CH_B  = 4'd4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_TRAILER = 2'd3
   } state_e;

   function automatic logic [31:0] header_word(input logic [3:0] chan, input logic [SEQ_W-1:0] seq);
      return {FRAME_MAGIC, chan, seq};
   endfunction

endpackage

// File: rtl/frame_out_reg.sv
// Single output register stage: loads a beat when told, holds it until the sink accepts it.
module frame_out_reg #(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              last,
   output logic              free
);

   assign free = !valid || ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_frame_packer.sv
// Packs channel-tagged stream records into headered frames of at most MAX_BEATS payload beats.
// Define FRAME_PACKER_TRAILER_EN to append a length/checksum trailer beat to each frame.
module stream_frame_packer
   import stream_frame_pkg::*;
#(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic [3:0]        s_axis_tid,
   input  logic              s_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              err_tid,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned PCNT_W = $clog2(MAX_BEATS + 1);

   state_e              state;
   logic [3:0]          chan_q;
   logic [SEQ_W-1:0]    seq;
   logic [PCNT_W-1:0]   pcnt;
   logic [PCNT_W-1:0]   pcnt_inc;
   logic                err_q;
   logic [CNT_W-1:0]    frame_q;
   logic                out_free;
   logic                accept;
   logic                close;
   logic                load;
   logic [DATA_W-1:0]   load_data;
   logic                load_last;
`ifdef FRAME_PACKER_TRAILER_EN
   logic [15:0]         csum;
`endif

   always_comb begin
      s_axis_tready = (state == ST_PAYLOAD) && out_free;
      accept        = s_axis_tvalid && s_axis_tready;
      pcnt_inc      = pcnt + 1'b1;
      close         = s_axis_tlast || (pcnt_inc == PCNT_W'(MAX_BEATS));
      load          = 1'b0;
      load_data     = '0;
      load_last     = 1'b0;
      case (state)
         ST_HEADER: begin
            if (out_free) begin
               load            = 1'b1;
               load_data[31:0] = header_word(chan_q, seq);
            end
         end
         ST_PAYLOAD: begin
            if (accept) begin
               load      = 1'b1;
               load_data = s_axis_tdata;
`ifdef FRAME_PACKER_TRAILER_EN
               load_last = 1'b0;
`else
               load_last = close;
`endif
            end
         end
`ifdef FRAME_PACKER_TRAILER_EN
         ST_TRAILER: begin
            if (out_free) begin
               load            = 1'b1;
               load_data[31:0] = {16'(pcnt), csum};
               load_last       = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state   <= ST_IDLE;
         chan_q  <= '0;
         seq     <= '0;
         pcnt    <= '0;
         err_q   <= 1'b0;
         frame_q <= '0;
`ifdef FRAME_PACKER_TRAILER_EN
         csum    <= '0;
`endif
      end else begin
         // Count on downstream acceptance of the closing beat, not on its load.
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
            frame_q <= frame_q + 1'b1;
         case (state)
            ST_IDLE: begin
               if (s_axis_tvalid) begin
                  chan_q <= s_axis_tid;
                  state  <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (out_free) begin
                  seq   <= seq + 1'b1;
                  pcnt  <= '0;
`ifdef FRAME_PACKER_TRAILER_EN
                  csum  <= '0;
`endif
                  state <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (accept) begin
                  pcnt <= pcnt_inc;
                  if (s_axis_tid != chan_q)
                     err_q <= 1'b1;
`ifdef FRAME_PACKER_TRAILER_EN
                  csum <= csum ^ s_axis_tdata[15:0];
                  if (close)
                     state <= ST_TRAILER;
`else
                  if (close)
                     state <= ST_IDLE;
`endif
               end
            end
`ifdef FRAME_PACKER_TRAILER_EN
            ST_TRAILER: begin
               if (out_free)
                  state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign err_tid   = err_q;
   assign frame_cnt = frame_q;

   frame_out_reg #(
      .DATA_W(DATA_W)
   ) u_out (
      .clk       (aclk),
      .rst       (areset),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .ready     (m_axis_tready),
      .valid     (m_axis_tvalid),
      .data      (m_axis_tdata),
      .last      (m_axis_tlast),
      .free      (out_free)
   );

endmodule

// File: tb/tb_stream_frame_packer.sv
// Directed, table-driven bench for stream_frame_packer (DATA_W=64, MAX_BEATS=16).
// Trailer expectations follow FRAME_PACKER_TRAILER_EN when it is defined.
module tb_stream_frame_packer;

   logic        aclk = 1'b0;
   logic        areset;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [63:0] s_axis_tdata;
   logic [3:0]  s_axis_tid;
   logic        s_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic        err_tid;
   logic [15:0] frame_cnt;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   bit          toggle_en = 1'b0;

   logic [64:0] got[$];
   logic [64:0] exp_q[$];

   typedef struct {
      logic [3:0]  tid;
      int unsigned nbeats;
      int unsigned chg_at;
      logic [3:0]  tid_b;
      bit          toggle;
      logic [31:0] exp_hdr0;
      logic [31:0] exp_hdr1;
      int unsigned exp_split;
      logic [15:0] exp_frames;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   stream_frame_packer #(
      .DATA_W    (64),
      .MAX_BEATS (16)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tid    (s_axis_tid),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .err_tid       (err_tid),
      .frame_cnt     (frame_cnt)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required finish", $time);
      $fatal(1);
   end

   initial forever begin
      @(posedge aclk);
      #1;
      if (toggle_en) m_axis_tready = !m_axis_tready;
      else           m_axis_tready = 1'b1;
   end

   initial forever begin
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tready)
         got.push_back({m_axis_tlast, m_axis_tdata});
   end

   function automatic logic [63:0] pay(input int unsigned r, input int unsigned b);
      return {16'hC0DE, 16'(r), 32'(b * 5 + 1)};
   endfunction

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [3:0] tid, input bit last);
      bit done;
      done          = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tid    = tid;
      s_axis_tlast  = last;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge aclk);
         if (s_axis_tready) begin
            @(posedge aclk);
            #1;
            done = 1'b1;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (!done) chk("accept_timeout", 65'd0, 65'd1);
   endtask

   task automatic check_stream(input string nm);
      for (int c = 0; c < 500 && got.size() < exp_q.size(); c++)
         @(negedge aclk);
      @(posedge aclk);
      #1;
      chk({nm, "_count"}, 65'(got.size()), 65'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s_beat%0d", nm, i), got[i], exp_q[i]);
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [63:0] d;
      logic [15:0] x;
      int unsigned cnt;
      bit          endf;

      vecs[0] = '{4'd2, 3,  3, 4'd2, 1'b0, 32'hE7A52000, 32'h0,        3,  16'd1, 1'b0};
      vecs[1] = '{4'd0, 20, 20, 4'd0, 1'b0, 32'hE7A50001, 32'hE7A50002, 16, 16'd3, 1'b0};
      vecs[2] = '{4'd4, 5,  5, 4'd4, 1'b1, 32'hE7A54003, 32'h0,        5,  16'd4, 1'b0};
      vecs[3] = '{4'd1, 16, 16, 4'd1, 1'b0, 32'hE7A51004, 32'h0,        16, 16'd5, 1'b0};
      vecs[4] = '{4'd3, 1,  1, 4'd3, 1'b0, 32'hE7A53005, 32'h0,        1,  16'd6, 1'b0};
      vecs[5] = '{4'd1, 4,  2, 4'd3, 1'b0, 32'hE7A51006, 32'h0,        4,  16'd7, 1'b1};

      areset        = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tid    = '0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_m_tvalid",  65'(m_axis_tvalid), 65'd0);
      chk("rst_m_tdata",   65'(m_axis_tdata),  65'd0);
      chk("rst_m_tlast",   65'(m_axis_tlast),  65'd0);
      chk("rst_s_tready",  65'(s_axis_tready), 65'd0);
      chk("rst_err_tid",   65'(err_tid),       65'd0);
      chk("rst_frame_cnt", 65'(frame_cnt),     65'd0);
      areset = 1'b0;

      for (int r = 0; r < 6; r++) begin
         exp_q.delete();
         got.delete();
         exp_q.push_back({1'b0, 32'h0, vecs[r].exp_hdr0});
         cnt = 0;
         x   = '0;
         for (int unsigned b = 0; b < vecs[r].nbeats; b++) begin
            d = pay(r, b);
            if (b == vecs[r].exp_split) begin
               exp_q.push_back({1'b0, 32'h0, vecs[r].exp_hdr1});
               cnt = 0;
               x   = '0;
            end
            cnt++;
            x    = x ^ d[15:0];
            endf = (b == vecs[r].exp_split - 1) || (b == vecs[r].nbeats - 1);
`ifdef FRAME_PACKER_TRAILER_EN
            exp_q.push_back({1'b0, d});
            if (endf) exp_q.push_back({1'b1, 32'h0, 16'(cnt), x});
`else
            exp_q.push_back({endf, d});
`endif
         end
         toggle_en = vecs[r].toggle;
         for (int unsigned b = 0; b < vecs[r].nbeats; b++)
            send_beat(pay(r, b), (b >= vecs[r].chg_at) ? vecs[r].tid_b : vecs[r].tid,
                      b == vecs[r].nbeats - 1);
         check_stream($sformatf("rec%0d", r));
         toggle_en = 1'b0;
         chk($sformatf("rec%0d_frame_cnt", r), 65'(frame_cnt), 65'(vecs[r].exp_frames));
         chk($sformatf("rec%0d_err_tid", r),   65'(err_tid),   65'(vecs[r].exp_err));
      end

      // Reset while the second beat of an 8-beat record is being offered.
      send_beat(pay(9, 0), 4'd2, 1'b0);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pay(9, 1);
      s_axis_tid    = 4'd2;
      @(negedge aclk);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      chk("midrst_m_tvalid",  65'(m_axis_tvalid), 65'd0);
      chk("midrst_m_tdata",   65'(m_axis_tdata),  65'd0);
      chk("midrst_m_tlast",   65'(m_axis_tlast),  65'd0);
      chk("midrst_s_tready",  65'(s_axis_tready), 65'd0);
      chk("midrst_err_tid",   65'(err_tid),       65'd0);
      chk("midrst_frame_cnt", 65'(frame_cnt),     65'd0);
      areset        = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pay(10, 0);
      s_axis_tid    = 4'd2;
      @(negedge aclk);
      chk("post_rst_s_tready", 65'(s_axis_tready), 65'd0);
      got.delete();
      exp_q.delete();
      exp_q.push_back({1'b0, 32'h0, 32'hE7A52000});
`ifdef FRAME_PACKER_TRAILER_EN
      exp_q.push_back({1'b0, pay(10, 0)});
      exp_q.push_back({1'b0, pay(10, 1)});
      exp_q.push_back({1'b1, 32'h0, 16'd2, 16'h0001 ^ 16'h0006});
`else
      exp_q.push_back({1'b0, pay(10, 0)});
      exp_q.push_back({1'b1, pay(10, 1)});
`endif
      send_beat(pay(10, 0), 4'd2, 1'b0);
      send_beat(pay(10, 1), 4'd2, 1'b1);
      check_stream("after_rst");
      chk("after_rst_frame_cnt", 65'(frame_cnt), 65'd1);

`ifdef FRAME_PACKER_TRAILER_EN
      exp_q.push_back({1'b0, 32'h0, 32'hE7A50001});
      exp_q.push_back({1'b0, 64'h1});
      exp_q.push_back({1'b0, 64'h3});
      exp_q.push_back({1'b1, 64'h0000_0000_0002_0002});
      send_beat(64'h1, 4'd0, 1'b0);
      send_beat(64'h3, 4'd0, 1'b1);
      check_stream("trailer");
      chk("trailer_frame_cnt", 65'(frame_cnt), 65'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
